srt_link_arbiter: RTL and testbench

SRT_LINK_ARBITER -- requirements
Module: srt_link_arbiter

---
 rtl/srt_link_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_srt_link_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_link_arbiter.sv
// Two-requester arbiter feeding a byte-serial SRT datapath: it grants fairly, retransmits on ERR or ack timeout, and captures received bytes.
// Optional retry: define SRT_ARB_RETRY_EN. Without it, any failed attempt drops the byte at once.
module srt_link_arbiter #(
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       send,
  output logic [7:0] d,
  output logic       en,
  input  logic       tx_ack,
  input  logic       rx_ack,
  input  logic       ERR,
  input  logic [7:0] Q,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [1:0] dbg_state
);

  // Handshake: a requester holds valid and data until its ready pulse; ready is
  // high for exactly the one cycle after the grant edge, and the byte is owned
  // by the arbiter from then on, whatever the requester does with valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(ACK_TIMEOUT);

  state_t     r_state;
  logic       r_ready0, r_ready1, r_send, r_en, r_busy, r_done, r_drop;
  logic       r_rx_valid, r_last, r_tx_ack_q, r_rx_ack_q;
  logic [7:0] r_d, r_rx_data, r_timer;
  logic [1:0] r_gnt;
`ifdef SRT_ARB_RETRY_EN
  localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);
  logic [7:0] r_retry;
`endif

  logic       w_tx_rise, w_rx_rise, w_ok, w_fail, w_pick1;
  logic [7:0] w_timer_inc;

  assign w_tx_rise   = tx_ack & ~r_tx_ack_q;
  assign w_rx_rise   = rx_ack & ~r_rx_ack_q;
  assign w_timer_inc = r_timer + 8'd1;
  // An ack edge wins over a simultaneous timeout; its ERR decides the outcome.
  assign w_ok        = w_tx_rise & ~ERR;
  assign w_fail      = w_tx_rise ? ERR : (w_timer_inc == LP_TIMEOUT);
  // r_last = 1 means requester 1 was served last, so 0 wins a tie.
  assign w_pick1     = req1_valid & (~req0_valid | ~r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_send     <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_d        <= 8'd0;
      r_gnt      <= 2'b00;
      r_timer    <= 8'd0;
      r_last     <= 1'b1;
      r_tx_ack_q <= 1'b0;
      r_rx_ack_q <= 1'b0;
`ifdef SRT_ARB_RETRY_EN
      r_retry    <= 8'd0;
`endif
    end else begin
      r_tx_ack_q <= tx_ack;
      r_rx_ack_q <= rx_ack;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_rx_valid <= 1'b0;
      if (w_rx_rise) begin
        r_rx_data  <= Q;
        r_rx_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
            r_last  <= w_pick1;
`ifdef SRT_ARB_RETRY_EN
            r_retry <= 8'd0;
`endif
            if (w_pick1) begin
              r_d      <= req1_data;
              r_gnt    <= 2'b10;
              r_ready1 <= 1'b1;
            end else begin
              r_d      <= req0_data;
              r_gnt    <= 2'b01;
              r_ready0 <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_SEND;
          r_send  <= 1'b1;
          r_timer <= 8'd0;
        end
        S_SEND: begin
          r_state <= S_WAIT;
          r_send  <= 1'b1;
        end
        S_WAIT: begin
          if (w_ok) begin
            r_state <= S_IDLE;
            r_send  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 1'b1;
          end else if (w_fail) begin
`ifdef SRT_ARB_RETRY_EN
            if (r_retry < LP_MAX_RETRY) begin
              // Retry: one SEND cycle with the strobe low, same byte.
              r_retry <= r_retry + 8'd1;
              r_state <= S_SEND;
              r_send  <= 1'b0;
              r_timer <= 8'd0;
            end else begin
              r_state <= S_IDLE;
              r_send  <= 1'b0;
              r_en    <= 1'b0;
              r_busy  <= 1'b0;
              r_gnt   <= 2'b00;
              r_drop  <= 1'b1;
            end
`else
            r_state <= S_IDLE;
            r_send  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= 2'b00;
            r_drop  <= 1'b1;
`endif
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign send       = r_send;
  assign d          = r_d;
  assign en         = r_en;
  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign drop       = r_drop;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_srt_link_arbiter.sv
// Directed bench for srt_link_arbiter (ACK_TIMEOUT=16, MAX_RETRY=3); expectations
// follow the SRT_ARB_RETRY_EN setting of the build.
module tb_srt_link_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       send, en, tx_ack, rx_ack, ERR;
  logic [7:0] d, Q, rx_data;
  logic [1:0] gnt, dbg_state;
  logic       busy, done, drop, rx_valid;

  int checks   = 0;
  int failures = 0;

  srt_link_arbiter #(.MAX_RETRY(3), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .send(send), .d(d), .en(en),
    .tx_ack(tx_ack), .rx_ack(rx_ack), .ERR(ERR), .Q(Q),
    .gnt(gnt), .busy(busy), .done(done), .drop(drop),
    .rx_data(rx_data), .rx_valid(rx_valid), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    tx_ack = 0; rx_ack = 0; ERR = 0; Q = 0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_send"},     {7'd0, send},       8'd0);
    chk({tag, "_d"},        d,                  8'd0);
    chk({tag, "_en"},       {7'd0, en},         8'd0);
    chk({tag, "_gnt"},      {6'd0, gnt},        8'd0);
    chk({tag, "_rdy0"},     {7'd0, req0_ready}, 8'd0);
    chk({tag, "_rdy1"},     {7'd0, req1_ready}, 8'd0);
    chk({tag, "_busy"},     {7'd0, busy},       8'd0);
    chk({tag, "_done"},     {7'd0, done},       8'd0);
    chk({tag, "_drop"},     {7'd0, drop},       8'd0);
    chk({tag, "_rx_valid"}, {7'd0, rx_valid},   8'd0);
    chk({tag, "_rx_data"},  rx_data,            8'd0);
    chk({tag, "_state"},    {6'd0, dbg_state},  8'd0);
  endtask

  int bursts[$];
  int cur;
  bit drop_seen;
  int exp_bursts;

  initial begin
    do_reset();
    chk_reset_vals("rst");

    // tx_ack edge while idle is ignored
    tx_ack = 1;
    step();
    chk("idle_ack_done", {7'd0, done}, 8'd0);
    chk("idle_ack_busy", {7'd0, busy}, 8'd0);
    tx_ack = 0;
    step();

    // Single byte A5 from requester 0, ack after 5 cycles
    req0_valid = 1; req0_data = 8'hA5;
    step();
    chk("t1_rdy0", {7'd0, req0_ready}, 8'd1);
    chk("t1_gnt",  {6'd0, gnt}, 8'h01);
    chk("t1_d",    d, 8'hA5);
    chk("t1_send_load", {7'd0, send}, 8'd0);
    chk("t1_en",   {7'd0, en}, 8'd1);
    req0_valid = 0; req0_data = 8'h00;
    step();
    chk("t1_send2", {7'd0, send}, 8'd1);
    chk("t1_rdy0_off", {7'd0, req0_ready}, 8'd0);
    step();
    chk("t1_state_wait", {6'd0, dbg_state}, 8'd3);
    step();
    step();
    tx_ack = 1;
    step();
    chk("t1_done", {7'd0, done}, 8'd1);
    chk("t1_drop", {7'd0, drop}, 8'd0);
    chk("t1_busy", {7'd0, busy}, 8'd0);
    chk("t1_gnt_idle", {6'd0, gnt}, 8'd0);
    chk("t1_en_idle", {7'd0, en}, 8'd0);
    chk("t1_d_held", d, 8'hA5);
    tx_ack = 0;
    step();
    chk("t1_done_pulse", {7'd0, done}, 8'd0);

    // Both requesters always valid: grants alternate starting with 0
    do_reset();
    req0_valid = 1; req0_data = 8'h11;
    req1_valid = 1; req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_gnt%0d", k), {6'd0, gnt}, (k % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("t2_rdy0_%0d", k), {7'd0, req0_ready}, (k % 2 == 0) ? 8'd1 : 8'd0);
      chk($sformatf("t2_rdy1_%0d", k), {7'd0, req1_ready}, (k % 2 == 0) ? 8'd0 : 8'd1);
      chk($sformatf("t2_d%0d", k), d, (k % 2 == 0) ? 8'h11 : 8'h22);
      step();
      step();
      tx_ack = 1;
      step();
      chk($sformatf("t2_done%0d", k), {7'd0, done}, 8'd1);
      tx_ack = 0;
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // ERR on first two acks, clean third
    do_reset();
    req0_valid = 1; req0_data = 8'h5A;
    step();
    req0_valid = 0;
    step();
    step();
    ERR = 1; tx_ack = 1;
    step();
`ifdef SRT_ARB_RETRY_EN
    chk("t3_gap1", {7'd0, send}, 8'd0);
    chk("t3_gap1_state", {6'd0, dbg_state}, 8'd2);
    chk("t3_gap1_drop", {7'd0, drop}, 8'd0);
    chk("t3_gap1_d", d, 8'h5A);
    tx_ack = 0;
    step();
    chk("t3_resend1", {7'd0, send}, 8'd1);
    tx_ack = 1;
    step();
    chk("t3_gap2", {7'd0, send}, 8'd0);
    chk("t3_gap2_drop", {7'd0, drop}, 8'd0);
    tx_ack = 0;
    step();
    chk("t3_resend2", {7'd0, send}, 8'd1);
    chk("t3_gnt", {6'd0, gnt}, 8'h01);
    ERR = 0; tx_ack = 1;
    step();
    chk("t3_done", {7'd0, done}, 8'd1);
    chk("t3_nodrop", {7'd0, drop}, 8'd0);
`else
    chk("t3_drop", {7'd0, drop}, 8'd1);
    chk("t3_done", {7'd0, done}, 8'd0);
    chk("t3_busy", {7'd0, busy}, 8'd0);
    chk("t3_send", {7'd0, send}, 8'd0);
`endif
    ERR = 0; tx_ack = 0;
    step();
    chk("t3_pulses_end", {6'd0, done, drop}, 8'd0);

    // No ack at all: every attempt waits 16 WAIT cycles; the first burst also
    // carries the strobe from the initial SEND cycle, retries have a low SEND gap.
    do_reset();
    req0_valid = 1; req0_data = 8'h77;
    step();
    req0_valid = 0;
    cur = 0;
    drop_seen = 0;
    bursts.delete();
    for (int n = 0; n < 200; n++) begin
      step();
      if (send) cur++;
      else if (cur > 0) begin
        bursts.push_back(cur);
        cur = 0;
      end
      if (drop) begin
        drop_seen = 1;
        break;
      end
    end
    chk("t4_drop_seen", {7'd0, drop_seen}, 8'd1);
    chk("t4_idle_at_drop", {6'd0, dbg_state}, 8'd0);
    chk("t4_busy_at_drop", {7'd0, busy}, 8'd0);
`ifdef SRT_ARB_RETRY_EN
    exp_bursts = 4;
`else
    exp_bursts = 1;
`endif
    chk("t4_bursts", 8'(bursts.size()), 8'(exp_bursts));
    foreach (bursts[i])
      chk($sformatf("t4_burst%0d_len", i), 8'(bursts[i]), (i == 0) ? 8'd17 : 8'd16);
    step();
    chk("t4_drop_pulse", {7'd0, drop}, 8'd0);

    // Ack edge on the very cycle the timer expires: ack wins
    do_reset();
    req1_valid = 1; req1_data = 8'hC3;
    step();
    chk("t5_gnt", {6'd0, gnt}, 8'h02);
    chk("t5_rdy1", {7'd0, req1_ready}, 8'd1);
    req1_valid = 0;
    for (int n = 0; n < 17; n++) step();
    chk("t5_still_wait", {6'd0, dbg_state}, 8'd3);
    chk("t5_send_high", {7'd0, send}, 8'd1);
    tx_ack = 1;
    step();
    chk("t5_done", {7'd0, done}, 8'd1);
    chk("t5_nodrop", {7'd0, drop}, 8'd0);
    chk("t5_send_low", {7'd0, send}, 8'd0);
    tx_ack = 0;
    step();

    // Reset during WAIT, then an rx capture
    do_reset();
    req0_valid = 1; req0_data = 8'h99;
    step();
    req0_valid = 0;
    step();
    step();
    step();
    chk("t6_in_wait", {6'd0, dbg_state}, 8'd3);
    rst = 0;
    #1;
    chk_reset_vals("t6_async");
    step();
    rst = 1;
    step();
    chk("t6_state", {6'd0, dbg_state}, 8'd0);
    chk("t6_nodrop", {7'd0, drop}, 8'd0);
    chk("t6_busy", {7'd0, busy}, 8'd0);
    Q = 8'h3C; rx_ack = 1;
    step();
    chk("t6_rx_valid", {7'd0, rx_valid}, 8'd1);
    chk("t6_rx_data", rx_data, 8'h3C);
    step();
    chk("t6_rx_valid_pulse", {7'd0, rx_valid}, 8'd0);
    chk("t6_rx_data_held", rx_data, 8'h3C);
    rx_ack = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
